// File: rtl/l2_ram_banked.sv
// Word-interleaved banked L2 memory behind a single req/gnt port, with a
// hardware zero-fill engine, a retention sleep/wake handshake and a read-valid strobe.

module l2_ram_bank #(
    parameter int DATA_WIDTH = 64,
    parameter int ROW_W      = 13
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic                    we_i,
    input  logic [ROW_W-1:0]        row_i,
    input  logic [DATA_WIDTH/8-1:0] ben_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);
    logic [DATA_WIDTH-1:0] mem [2**ROW_W];

    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            for (int i = 0; i < DATA_WIDTH/8; i++) begin
                if (ben_i[i]) mem[row_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    // Read register holds between reads so the top-level mux output is stable.
    always_ff @(posedge clk_i) begin
        if (!rst_ni)                rdata_o <= '0;
        else if (en_i && !we_i)     rdata_o <= mem[row_i];
    end
endmodule

module l2_ram_banked #(
    parameter int DATA_WIDTH      = 64,
    parameter int NB_BANKS        = 4,
    parameter int BANK_ADDR_WIDTH = 13,
    parameter int WAKE_CYCLES     = 4,
    parameter int ZERO_INIT       = 1,
    localparam int BANK_SEL   = (NB_BANKS > 1) ? $clog2(NB_BANKS) : 0,
    localparam int ADDR_WIDTH = BANK_SEL + BANK_ADDR_WIDTH,
    localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  init_ni,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [ADDR_WIDTH-1:0] add_i,
    input  logic                  wen_i,
    input  logic [BE_WIDTH-1:0]   ben_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    input  logic                  sleep_req_i,
    output logic                  sleep_ack_o,
    output logic                  init_done_o,
    input  logic                  test_mode_i
);
    localparam int BSW = (BANK_SEL > 0) ? BANK_SEL : 1;
    localparam int WW  = $clog2(WAKE_CYCLES + 1);

    typedef enum logic [2:0] {INIT, ACTIVE, SLEEP_WAIT, SLEEP, WAKE} state_e;

    state_e                                 state;
    logic [BANK_ADDR_WIDTH-1:0]             cnt;
    logic [WW-1:0]                          wcnt;
    logic [BSW-1:0]                         bank_sel, rsel_q;
    logic [BANK_ADDR_WIDTH-1:0]             row;
    logic                                   leave_active, fill;
    logic [NB_BANKS-1:0][DATA_WIDTH-1:0]    bank_rdata;

    generate
        if (BANK_SEL == 0) begin : g_one_bank
            assign bank_sel = '0;
            assign row      = add_i;
        end else begin : g_multi_bank
            assign bank_sel = add_i[BANK_SEL-1:0];
            assign row      = add_i[ADDR_WIDTH-1:BANK_SEL];
        end
    endgenerate

    assign leave_active = !init_ni || sleep_req_i;
    assign gnt_o        = rst_ni && (state == ACTIVE) && !leave_active && req_i;
    assign fill         = rst_ni && (state == INIT) && init_ni;
    assign init_done_o  = rst_ni && (state != INIT);
    assign sleep_ack_o  = (state == SLEEP);
    assign rdata_o      = bank_rdata[rsel_q];

    // During fill every bank writes zero to the same row in parallel.
    generate
        for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
            l2_ram_bank #(.DATA_WIDTH(DATA_WIDTH), .ROW_W(BANK_ADDR_WIDTH)) u_bank (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .en_i    (fill || (gnt_o && (bank_sel == BSW'(b)))),
                .we_i    (fill || !wen_i),
                .row_i   (fill ? cnt : row),
                .ben_i   (fill ? {BE_WIDTH{1'b1}} : ben_i),
                .wdata_i (fill ? {DATA_WIDTH{1'b0}} : wdata_i),
                .rdata_o (bank_rdata[b])
            );
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvalid_o <= 1'b0;
            rsel_q   <= '0;
        end else begin
            rvalid_o <= gnt_o && wen_i;
            if (gnt_o && wen_i) rsel_q <= bank_sel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= (ZERO_INIT != 0 && !test_mode_i) ? INIT : ACTIVE;
            cnt   <= '0;
            wcnt  <= '0;
        end else begin
            case (state)
                INIT: begin
                    if (!init_ni) cnt <= '0;
                    else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == {BANK_ADDR_WIDTH{1'b1}}) state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (!init_ni) begin
                        state <= INIT;
                        cnt   <= '0;
                    end else if (sleep_req_i) state <= SLEEP_WAIT;
                end
                // The leaving cycle grants nothing, so the last read returns
                // during that cycle and one wait cycle is enough.
                SLEEP_WAIT: state <= SLEEP;
                SLEEP: begin
                    if (!sleep_req_i) begin
                        state <= WAKE;
                        wcnt  <= '0;
                    end
                end
                WAKE: begin
                    if (wcnt == WW'(WAKE_CYCLES - 1)) state <= ACTIVE;
                    else                              wcnt  <= wcnt + 1'b1;
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_ram_banked.sv
// Directed bench for l2_ram_banked: reads are scoreboarded with their due cycle,
// a negedge monitor pops and compares on every rvalid.

module tb_l2_ram_banked;
    localparam int DW  = 64;
    localparam int AW  = 6;
    localparam int BEW = 8;

    logic clk = 0, rst_ni = 0, init_ni = 1, req_i = 0, wen_i = 1;
    logic sleep_req_i = 0, test_mode_i = 0;
    logic [AW-1:0]  add_i   = '0;
    logic [BEW-1:0] ben_i   = '0;
    logic [DW-1:0]  wdata_i = '0;
    logic gnt_o, rvalid_o, sleep_ack_o, init_done_o;
    logic [DW-1:0] rdata_o;

    l2_ram_banked #(
        .DATA_WIDTH(64), .NB_BANKS(4), .BANK_ADDR_WIDTH(4), .WAKE_CYCLES(4), .ZERO_INIT(1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .init_ni(init_ni), .req_i(req_i), .gnt_o(gnt_o),
        .add_i(add_i), .wen_i(wen_i), .ben_i(ben_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .sleep_req_i(sleep_req_i),
        .sleep_ack_o(sleep_ack_o), .init_done_o(init_done_o), .test_mode_i(test_mode_i)
    );

    always #5 clk = ~clk;

    typedef struct {logic [DW-1:0] data; int due;} exp_t;
    exp_t sb[$];
    int negcnt = 0, n_pass = 0, n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        exp_t e;
        negcnt++;
        if (rvalid_o === 1'b1) begin
            if (sb.size() == 0) chk("rv_spurious", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                chk("rdata", rdata_o, e.data);
                chk("rv_latency", 64'(negcnt), 64'(e.due));
            end
        end
    end

    // Present one request and wait (bounded) for its grant; reads expect d.
    task automatic access(input logic rd, input logic [AW-1:0] a,
                          input logic [BEW-1:0] be, input logic [DW-1:0] d);
        int b;
        @(negedge clk);
        req_i = 1; wen_i = rd; add_i = a; ben_i = be; wdata_i = d;
        #4; b = 0;
        while (gnt_o !== 1'b1 && b < 20) begin
            @(negedge clk); #4; b++;
        end
        chk("gnt_seen", 64'(gnt_o), 64'd1);
        if (gnt_o === 1'b1 && rd) sb.push_back('{d, negcnt + 1});
    endtask

    task automatic idle();
        @(negedge clk);
        req_i = 0;
    endtask

    // Called right after a negedge with a read of a zero-filled address
    // pending: gnt/init_done stay low for 16 cycles, then rise together.
    task automatic fill_check(input string nm);
        for (int k = 0; k <= 16; k++) begin
            #4;
            chk(nm, 64'({gnt_o, init_done_o}), 64'({k == 16, k == 16}));
            if (k == 16 && gnt_o === 1'b1) sb.push_back('{64'h0, negcnt + 1});
            else if (k < 16) @(negedge clk);
        end
        @(negedge clk);
        req_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, then the power-on fill; read 0x3F once usable.
        req_i = 1; wen_i = 1; add_i = 6'h3F;
        repeat (2) @(negedge clk);
        #4;
        chk("rst_outs", 64'({gnt_o, rvalid_o, sleep_ack_o, init_done_o}), 64'd0);
        chk("rst_rdata", rdata_o, 64'd0);
        @(negedge clk); rst_ni = 1;
        fill_check("fill_after_rst");

        // Byte-enable merge.
        access(0, 6'd5, 8'hFF, 64'h1122334455667788);
        access(0, 6'd5, 8'h0F, 64'hAAAAAAAABBBBBBBB);
        access(1, 6'd5, 8'h00, 64'h11223344BBBBBBBB);
        idle();

        // Interleaved writes then eight back-to-back reads.
        for (int k = 0; k < 8; k++) access(0, AW'(k), 8'hFF, 64'(k));
        for (int k = 0; k < 8; k++) access(1, AW'(k), 8'h00, 64'(k));
        idle();

        // Sleep with a read in flight, init_ni ignored while asleep, then wake.
        access(0, 6'd3, 8'hFF, 64'hDEAD);
        access(1, 6'd3, 8'h00, 64'hDEAD);
        @(negedge clk); sleep_req_i = 1; req_i = 1; wen_i = 1; add_i = 6'd3;
        #4 chk("slp_leave", 64'({gnt_o, sleep_ack_o}), 64'b00);
        @(negedge clk); #4 chk("slp_wait", 64'({gnt_o, sleep_ack_o}), 64'b00);
        @(negedge clk); #4 chk("slp_ack", 64'({gnt_o, sleep_ack_o}), 64'b01);
        @(negedge clk); init_ni = 0;
        #4 chk("slp_init_ign", 64'({gnt_o, sleep_ack_o, init_done_o}), 64'b011);
        @(negedge clk); init_ni = 1; sleep_req_i = 0;
        #4 chk("slp_exit", 64'({gnt_o, sleep_ack_o}), 64'b01);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk); #4;
            chk("wake", 64'({gnt_o, sleep_ack_o}), 64'({j == 5, 1'b0}));
            if (j == 5 && gnt_o === 1'b1) sb.push_back('{64'hDEAD, negcnt + 1});
        end
        idle();

        // init_ni low for 3 cycles in ACTIVE re-runs the fill.
        access(0, 6'd2, 8'hFF, 64'h0123456789ABCDEF);
        @(negedge clk); init_ni = 0; req_i = 1; wen_i = 1; add_i = 6'd2;
        #4 chk("init_leave", 64'({gnt_o, init_done_o}), 64'b01);
        @(negedge clk); #4 chk("init_low1", 64'({gnt_o, init_done_o}), 64'b00);
        @(negedge clk); #4 chk("init_low2", 64'({gnt_o, init_done_o}), 64'b00);
        @(negedge clk); init_ni = 1;
        fill_check("refill");
        access(1, 6'd5, 8'h00, 64'h0);
        idle();

        // Reset while the fill is at row 7; fill restarts after release.
        access(0, 6'd9, 8'hFF, 64'h5555AAAA5555AAAA);
        access(1, 6'd9, 8'h00, 64'h5555AAAA5555AAAA);
        @(negedge clk); req_i = 0; init_ni = 0;
        @(negedge clk); init_ni = 1;
        repeat (7) @(negedge clk);
        rst_ni = 0; req_i = 1; wen_i = 1; add_i = 6'h3F;
        #4 chk("midrst_gnt", 64'({gnt_o, init_done_o}), 64'b00);
        @(negedge clk); #4;
        chk("midrst_outs", 64'({gnt_o, rvalid_o, sleep_ack_o, init_done_o}), 64'd0);
        chk("midrst_rdata", rdata_o, 64'd0);
        @(negedge clk); rst_ni = 1;
        fill_check("fill_after_midrst");

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
